// File: rtl/vga_mem_scan.sv
`default_nettype none
// ============================================================================
// vga_mem_scan : once per frame, sweeps a ROM/RAM word window into a display
//                buffer, sharing one synchronous memory read port with a CPU.
// Revision     : 1.0
// ============================================================================
module vga_mem_scan #(
  parameter int          WORDS      = 128,
  parameter logic [31:0] ROM_BASE   = 32'h0000_0000,
  parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
  parameter int          STARVE_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        vs,
  input  logic        sel_ram,
  input  logic        page,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        buf_we,
  output logic [7:0]  buf_addr,
  output logic [31:0] buf_data,
  output logic        busy,
  output logic        done
);

  localparam int            SW         = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [6:0]    IDX_LAST   = 7'(WORDS - 1);
  localparam logic [31:0]   PAGE_BYTES = 32'(WORDS * 4);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_SCAN    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          vs_q, vs_d;
  logic [6:0]    idx_q, idx_d;
  logic [6:0]    pend_idx_q, pend_idx_d;
  logic          pend_q, pend_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          sel_ram_q, sel_ram_d;
  logic          page_q, page_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic          done_q, done_d;

  logic          vs_rise;
  logic          force_scan;
  logic [31:0]   scan_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vs_q         <= 1'b0;
      idx_q        <= 7'd0;
      pend_idx_q   <= 7'd0;
      pend_q       <= 1'b0;
      starve_q     <= '0;
      sel_ram_q    <= 1'b0;
      page_q       <= 1'b0;
      mem_addr_q   <= 32'd0;
      cpu_rvalid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= vs_d;
      idx_q        <= idx_d;
      pend_idx_q   <= pend_idx_d;
      pend_q       <= pend_d;
      starve_q     <= starve_d;
      sel_ram_q    <= sel_ram_d;
      page_q       <= page_d;
      mem_addr_q   <= mem_addr_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    vs_rise    = vs & ~vs_q;
    force_scan = (state_q == ST_SCAN) && (starve_q == STARVE_LIM);
    cpu_gnt    = cpu_req & ~force_scan;
    scan_addr  = (sel_ram_q ? RAM_BASE : ROM_BASE) + (page_q ? PAGE_BYTES : 32'd0)
               + {23'd0, idx_q, 2'b00};

    state_d      = state_q;
    vs_d         = vs;
    idx_d        = idx_q;
    pend_idx_d   = pend_idx_q;
    pend_d       = 1'b0;
    starve_d     = starve_q;
    sel_ram_d    = sel_ram_q;
    page_d       = page_q;
    cpu_rvalid_d = cpu_gnt;
    done_d       = 1'b0;

    // The port keeps its last address whenever nobody is reading.
    if (cpu_gnt)
      mem_addr_d = cpu_addr;
    else if (state_q == ST_SCAN)
      mem_addr_d = scan_addr;
    else
      mem_addr_d = mem_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (vs_rise) begin
          sel_ram_d = sel_ram;
          page_d    = page;
          idx_d     = 7'd0;
          starve_d  = '0;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (cpu_gnt) begin
          if (starve_q != STARVE_LIM) starve_d = starve_q + SW'(1);
        end else begin
          pend_d     = 1'b1;
          pend_idx_d = idx_q;
          idx_d      = idx_q + 7'd1;
          starve_d   = '0;
          if (idx_q == IDX_LAST) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        done_d  = 1'b1;
        state_d = en ? ST_WAIT_VS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr   = mem_addr_d;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = mem_rdata;
  assign buf_we     = pend_q;
  assign buf_addr   = pend_q ? {sel_ram_q, pend_idx_q} : 8'd0;
  assign buf_data   = pend_q ? mem_rdata : 32'd0;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_mem_scan.sv
`default_nettype none
// ============================================================================
// tb_vga_mem_scan : directed self-checking bench for vga_mem_scan (WORDS=4).
// Revision        : 1.0
// ============================================================================
module tb_vga_mem_scan;

  localparam int          WORDS  = 4;
  localparam logic [31:0] RAM_B  = 32'h0000_1000;
  localparam logic [31:0] CPU_A  = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, vs = 1'b0, sel_ram = 1'b0, page = 1'b0, cpu_req = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic        cpu_gnt, cpu_rvalid, buf_we, busy, done;
  logic [31:0] cpu_rdata, mem_addr, buf_data;
  logic [7:0]  buf_addr;

  int total = 0;
  int bad   = 0;

  vga_mem_scan #(
    .WORDS(WORDS), .ROM_BASE(32'h0), .RAM_BASE(RAM_B), .STARVE_MAX(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .vs(vs), .sel_ram(sel_ram), .page(page),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_data(buf_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory whose word at byte address a holds a, one cycle read latency.
  always @(posedge clk) mem_rdata <= mem_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle at the falling edge, then let outputs settle.
  task automatic cyc(input logic e, input logic v, input logic s, input logic p,
                     input logic r, input logic [31:0] a);
    @(negedge clk);
    en = e; vs = v; sel_ram = s; page = p; cpu_req = r; cpu_addr = a;
    #1;
  endtask

  // Starts from WAIT_VS; sel/page are inverted mid-sweep to show they are latched.
  task automatic sweep(input logic s, input logic p, input logic [31:0] base,
                       input logic vs_mid);
    cyc(1'b1, 1'b1, s, p, 1'b0, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < WORDS; k++) begin
      cyc(1'b1, vs_mid && (k == 1), ~s, ~p, 1'b0, 32'd0);
      chk("scan_addr", mem_addr, base + 32'(4 * k));
      chk("scan_we", {31'd0, buf_we}, (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) begin
        chk("scan_baddr", {24'd0, buf_addr}, {24'd0, s, 7'(k - 1)});
        chk("scan_bdata", buf_data, base + 32'(4 * (k - 1)));
      end
      chk("scan_done", {31'd0, done}, 32'd0);
    end
    cyc(1'b1, 1'b0, ~s, ~p, 1'b0, 32'd0);
    chk("drain_we", {31'd0, buf_we}, 32'd1);
    chk("drain_baddr", {24'd0, buf_addr}, {24'd0, s, 7'(WORDS - 1)});
    chk("drain_bdata", buf_data, base + 32'(4 * (WORDS - 1)));
    chk("drain_done", {31'd0, done}, 32'd0);
    cyc(1'b1, 1'b0, s, p, 1'b0, 32'd0);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_we", {31'd0, buf_we}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd1);
    cyc(1'b1, 1'b0, s, p, 1'b0, 32'd0);
    chk("done_low", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic g;
    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_we", {31'd0, buf_we}, 32'd0);
    chk("rst_baddr", {24'd0, buf_addr}, 32'd0);
    chk("rst_bdata", buf_data, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    rst_n = 1'b1;

    // CPU read while idle
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    chk("idle_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("idle_maddr", mem_addr, 32'h40);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("idle_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("idle_rdata", cpu_rdata, 32'h40);
    chk("idle_hold", mem_addr, 32'h40);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("idle_rvalid0", {31'd0, cpu_rvalid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Plain ROM sweep, then RAM page 1
    sweep(1'b0, 1'b0, 32'h0, 1'b0);
    sweep(1'b1, 1'b1, RAM_B + 32'h10, 1'b0);

    // CPU hammering the port for the whole sweep
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < WORDS * 16; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, CPU_A);
      g = ((k % 16) != 15);
      chk("st_gnt", {31'd0, cpu_gnt}, {31'd0, g});
      chk("st_maddr", mem_addr, g ? CPU_A : 32'(4 * (k / 16)));
      chk("st_we", {31'd0, buf_we}, ((k > 0) && (k % 16 == 0)) ? 32'd1 : 32'd0);
      chk("st_rvalid", {31'd0, cpu_rvalid}, ((k > 0) && ((k - 1) % 16 != 15)) ? 32'd1 : 32'd0);
      if ((k > 0) && (k % 16 == 0))
        chk("st_bdata", buf_data, 32'(4 * (k / 16 - 1)));
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, CPU_A);
    chk("st_drain_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("st_drain_we", {31'd0, buf_we}, 32'd1);
    chk("st_drain_bdata", buf_data, 32'hC);
    chk("st_drain_excl", {31'd0, cpu_rvalid}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("st_done", {31'd0, done}, 32'd1);
    chk("st_last_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("st_last_rdata", cpu_rdata, CPU_A);
    chk("st_done_we", {31'd0, buf_we}, 32'd0);

    // en dropped after two issues
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("ab_we0", {31'd0, buf_we}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("ab_we1", {31'd0, buf_we}, 32'd1);
    chk("ab_bdata1", buf_data, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("ab_we2", {31'd0, buf_we}, 32'd1);
    chk("ab_baddr2", {24'd0, buf_addr}, 32'd1);
    chk("ab_bdata2", buf_data, 32'h4);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("ab_we_off", {31'd0, buf_we}, 32'd0);
      chk("ab_busy", {31'd0, busy}, 32'd0);
      chk("ab_done", {31'd0, done}, 32'd0);
    end

    // Reset asserted mid-sweep
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("mr_pre_we", {31'd0, buf_we}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk("mr_we", {31'd0, buf_we}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_done", {31'd0, done}, 32'd0);
    chk("mr_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("mr_maddr", mem_addr, 32'd0);
    chk("mr_baddr", {24'd0, buf_addr}, 32'd0);
    chk("mr_bdata", buf_data, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("mr_hold_we", {31'd0, buf_we}, 32'd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("mr_idle_we", {31'd0, buf_we}, 32'd0);
      chk("mr_idle_busy", {31'd0, busy}, 32'd0);
    end
    // en and vs together in IDLE: the edge is missed
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("mr_en_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("mr_wait_busy", {31'd0, busy}, 32'd1);
      chk("mr_wait_we", {31'd0, buf_we}, 32'd0);
    end

    // vs pulse in the middle of a sweep
    sweep(1'b0, 1'b1, 32'h10, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
